// File: rtl/music_pkg.sv
// Shared types and default timing constants for the note playback scheduler.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TEMPO_1X   = 2'b00,
    TEMPO_HALF = 2'b01,
    TEMPO_QTR  = 2'b10,
    TEMPO_2X   = 2'b11
  } tempo_e;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_NOTE_TICKS = 25_000_000;
  localparam int DEF_GAP_TICKS  = 2_500_000;

  // A scaled duration of zero would skip a note entirely, so never go below 1.
  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/playback_scheduler_tick_timer.sv
// Loadable down-counter shared by the PLAY and GAP phases; stops at zero.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/playback_scheduler.sv
// Steps note_counter through the recorded notes with tempo-scaled play/gap timing.
// Define PLAYBACK_LOOP_EN to wrap back to the first note instead of finishing.
module playback_scheduler
  import music_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NOTE_TICKS = DEF_NOTE_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  localparam int TW        = $clog2(2 * NOTE_TICKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        tempo,
  input  logic [ADDR_W:0]   notes_recorded,
  output logic [ADDR_W-1:0] note_counter,
  output logic              ld_play,
  output logic              next_note_en,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg,
  output logic [TW-1:0]     timer_dbg
);

  // Timer reload values are duration-1 so a phase lasts exactly its duration.
  localparam logic [TW-1:0] LD_1X   = TW'(clamp1(NOTE_TICKS) - 1);
  localparam logic [TW-1:0] LD_HALF = TW'(clamp1(NOTE_TICKS / 2) - 1);
  localparam logic [TW-1:0] LD_QTR  = TW'(clamp1(NOTE_TICKS / 4) - 1);
  localparam logic [TW-1:0] LD_2X   = TW'(clamp1(NOTE_TICKS * 2) - 1);
  localparam logic [TW-1:0] LD_GAP  = TW'(clamp1(GAP_TICKS) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] nc_q, nc_d;
  logic              nne_q, nne_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic [TW-1:0]     tmr_value;
  logic              tmr_zero;
  logic [TW-1:0]     dur_ld;
  logic              last_note;

  tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    dur_ld = LD_1X;
    case (tempo_e'(tempo))
      TEMPO_1X:   dur_ld = LD_1X;
      TEMPO_HALF: dur_ld = LD_HALF;
      TEMPO_QTR:  dur_ld = LD_QTR;
      TEMPO_2X:   dur_ld = LD_2X;
      default:    dur_ld = LD_1X;
    endcase
  end

  assign last_note = ({1'b0, nc_q} == (cnt_q - 1'b1));

  // Handshake: start is honoured only in IDLE and only when stop is low in the
  // same cycle; stop aborts LOAD/PLAY/GAP into DONE and is ignored elsewhere.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nc_d     = nc_q;
    nne_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dur_ld;
    case (state_q)
      IDLE: begin
        if (start && !stop) state_d = LOAD;
      end
      LOAD: begin
        cnt_d = notes_recorded;
        nc_d  = '0;
        if (stop || (notes_recorded == '0)) begin
          state_d = DONE;
        end else begin
          state_d  = PLAY;
          tmr_load = 1'b1;
          nne_d    = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = DONE;
        end else if (tmr_zero) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = LD_GAP;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = DONE;
        end else if (tmr_zero) begin
          if (last_note) begin
`ifdef PLAYBACK_LOOP_EN
            state_d  = PLAY;
            nc_d     = '0;
            tmr_load = 1'b1;
            nne_d    = 1'b1;
`else
            state_d  = DONE;
`endif
          end else begin
            state_d  = PLAY;
            nc_d     = nc_q + 1'b1;
            tmr_load = 1'b1;
            nne_d    = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) nc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nc_q    <= '0;
      nne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nc_q    <= nc_d;
      nne_q   <= nne_d;
    end
  end

  assign note_counter = nc_q;
  assign ld_play      = (state_q == PLAY);
  assign next_note_en = nne_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign state_dbg    = state_q;
  assign timer_dbg    = tmr_value;

endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench for playback_scheduler with NOTE_TICKS=8, GAP_TICKS=2.
module tb_playback_scheduler;
  import music_pkg::*;

  localparam int ADDR_W     = 4;
  localparam int NOTE_TICKS = 8;
  localparam int GAP_TICKS  = 2;
  localparam int TW         = $clog2(2 * NOTE_TICKS + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic [1:0]        tempo;
  logic [ADDR_W:0]   notes_recorded;
  logic [ADDR_W-1:0] note_counter;
  logic              ld_play;
  logic              next_note_en;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;
  logic [TW-1:0]     timer_dbg;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  playback_scheduler #(
    .ADDR_W     (ADDR_W),
    .NOTE_TICKS (NOTE_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .tempo          (tempo),
    .notes_recorded (notes_recorded),
    .note_counter   (note_counter),
    .ld_play        (ld_play),
    .next_note_en   (next_note_en),
    .busy           (busy),
    .done           (done),
    .state_dbg      (state_dbg),
    .timer_dbg      (timer_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Returns positioned one edge after start was sampled (k=1, LOAD).
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic sb_note(input string tag);
    if (next_note_en) begin
      check(tag, note_counter, (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hdead);
    end
  endtask

  initial begin
    tempo          = 2'b00;
    notes_recorded = '0;
    do_reset();

    // reset state
    check("rst_nc",    note_counter, 0);
    check("rst_ld",    ld_play, 0);
    check("rst_nne",   next_note_en, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_state", state_dbg, IDLE);

`ifndef PLAYBACK_LOOP_EN
    // three notes at 1x: 8 on, 2 off per note, done at k=32
    notes_recorded = 5'd3;
    exp_q = {};
    for (int i = 0; i < 3; i++) exp_q.push_back(ADDR_W'(i));
    kick();
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) tick();
      check($sformatf("t1_ld_k%0d", k), ld_play,
            (k >= 2 && k <= 31 && ((k - 2) % 10) < 8));
      check($sformatf("t1_nne_k%0d", k), next_note_en,
            (k >= 2 && k <= 31 && ((k - 2) % 10) == 0));
      check($sformatf("t1_done_k%0d", k), done, (k == 32));
      check($sformatf("t1_busy_k%0d", k), busy, (k >= 1 && k <= 32));
      if (k >= 2 && k <= 31) check($sformatf("t1_nc_k%0d", k), note_counter, (k - 2) / 10);
      if (k == 2) check("t1_timer_entry", timer_dbg, NOTE_TICKS - 1);
      sb_note("t1_sb_nc");
    end
    check("t1_sb_left", exp_q.size(), 0);
`endif

    // zero notes: LOAD then DONE, nothing audible
    notes_recorded = 5'd0;
    kick();
    check("t2_load", state_dbg, LOAD);
    check("t2_ld_k1", ld_play, 0);
    tick();
    check("t2_done", done, 1);
    check("t2_ld_k2", ld_play, 0);
    check("t2_nne_k2", next_note_en, 0);
    tick();
    check("t2_idle", busy, 0);

    // stop in cycle 3 of the second note (k=14)
    notes_recorded = 5'd4;
    kick();
    run(13);
    check("t3_nc_before", note_counter, 1);
    check("t3_ld_before", ld_play, 1);
    pulse_stop();
    check("t3_ld_stop", ld_play, 0);
    check("t3_done_stop", done, 1);
    tick();
    check("t3_busy_after", busy, 0);
    check("t3_nc_after", note_counter, 0);
    check("t3_done_after", done, 0);

    // stop+start together in IDLE: start dropped
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t4_both_busy", busy, 0);
    tick();
    check("t4_both_busy2", busy, 0);

    // start during PLAY: no effect on counter or timing
    notes_recorded = 5'd3;
    kick();
    run(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_nc_k5", note_counter, 0);
    check("t4_ld_k5", ld_play, 1);
    check("t4_nne_k5", next_note_en, 0);
    run(4);
    check("t4_ld_k9", ld_play, 1);
    tick();
    check("t4_ld_k10", ld_play, 0);
    run(2);
    check("t4_nne_k12", next_note_en, 1);
    check("t4_nc_k12", note_counter, 1);
    pulse_stop();
    check("t4_done", done, 1);
    tick();
    check("t4_idle", busy, 0);

`ifndef PLAYBACK_LOOP_EN
    // tempo 2x for note 0, switched to 1/4 mid-note; notes_recorded changed too
    notes_recorded = 5'd3;
    tempo = 2'b11;
    kick();
    run(4);
    tempo = 2'b10;
    notes_recorded = 5'd1;
    run(12);
    check("t5_ld_k17", ld_play, 1);
    tick();
    check("t5_ld_k18", ld_play, 0);
    run(2);
    check("t5_nne_k20", next_note_en, 1);
    check("t5_nc_k20", note_counter, 1);
    tick();
    check("t5_ld_k21", ld_play, 1);
    tick();
    check("t5_ld_k22", ld_play, 0);
    run(2);
    check("t5_nne_k24", next_note_en, 1);
    check("t5_nc_k24", note_counter, 2);
    run(4);
    check("t5_done_k28", done, 1);
    tick();
    check("t5_idle", busy, 0);

    // full store of 16 notes at 1/4 tempo: period 4, done at k=66
    notes_recorded = 5'd16;
    tempo = 2'b10;
    kick();
    for (int k = 1; k <= 67; k++) begin
      if (k > 1) tick();
      check($sformatf("t7_nne_k%0d", k), next_note_en, (k >= 2 && k <= 62 && ((k - 2) % 4) == 0));
      check($sformatf("t7_done_k%0d", k), done, (k == 66));
      if (k >= 2 && k <= 65) check($sformatf("t7_nc_k%0d", k), note_counter, (k - 2) / 4);
    end
    check("t7_idle", busy, 0);
    tempo = 2'b00;
`else
    // looping: 0,1,0,1,... until stop
    notes_recorded = 5'd2;
    tempo = 2'b00;
    exp_q = {};
    for (int i = 0; i < 5; i++) exp_q.push_back(ADDR_W'(i % 2));
    kick();
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) tick();
      check($sformatf("t6_nne_k%0d", k), next_note_en, (k >= 2 && ((k - 2) % 10) == 0));
      check($sformatf("t6_done_k%0d", k), done, 0);
      if (k >= 2) check($sformatf("t6_nc_k%0d", k), note_counter, ((k - 2) / 10) % 2);
      sb_note("t6_sb_nc");
    end
    check("t6_sb_left", exp_q.size(), 0);
    pulse_stop();
    check("t6_done_stop", done, 1);
    tick();
    check("t6_idle", busy, 0);
`endif

    // reset while in GAP
    notes_recorded = 5'd2;
    tempo = 2'b00;
    kick();
    run(9);
    check("t8_in_gap", state_dbg, GAP);
    reset = 1'b1;
    tick();
    check("t8_nc",    note_counter, 0);
    check("t8_ld",    ld_play, 0);
    check("t8_nne",   next_note_en, 0);
    check("t8_busy",  busy, 0);
    check("t8_done",  done, 0);
    check("t8_timer", timer_dbg, 0);
    reset = 1'b0;
    tick();
    check("t8_stay_idle", busy, 0);
    check("t8_no_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
